// File: rtl/axis_hdr_insert_pipe_if.sv
// Stream, header and status signals of the header inserter, grouped so the
// block drops in with its original signal names behind a single port.
interface axis_hdr_insert_pipe_if #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned CNT_WD       = 16
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      header_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic                    ready_insert;

    logic [CNT_WD-1:0]       pkt_cnt;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out,
        input  valid_insert, header_insert, keep_insert,
        output ready_insert,
        output pkt_cnt
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out,
        output valid_insert, header_insert, keep_insert,
        input  ready_insert,
        input  pkt_cnt
    );
endinterface

// File: rtl/axis_hdr_insert_pipe.sv
// Prepends a 0..N byte header to each AXI-Stream packet, re-aligning payload
// bytes behind it, through a registered output slice with full backpressure.
module axis_hdr_insert_pipe #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned CNT_WD       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_hdr_insert_pipe_if.slave bus
);
    localparam int unsigned CW     = $clog2(DATA_BYTE_WD + 1);
    localparam logic [CW:0] NBYTES = (CW + 1)'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

    function automatic logic [CW:0] popcnt(input logic [DATA_BYTE_WD-1:0] v);
        logic [CW:0] c;
        c = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + {{CW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [CW:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CW:0]             r_q, r_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    logic [CNT_WD-1:0]       pkt_cnt_q, pkt_cnt_d;

    logic                    load;
    logic                    rdy_in;
    logic                    rdy_ins;
    logic [CW:0]             h_cnt;
    logic [CW:0]             k_cnt;
    logic [CW:0]             sum;
    logic [DATA_WD-1:0]      din_m;
    logic [2*DATA_WD-1:0]    cat;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        r_d         = r_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        pkt_cnt_d   = pkt_cnt_q;
        rdy_in      = 1'b0;
        rdy_ins     = 1'b0;

        load  = !valid_out_q || bus.ready_out;
        h_cnt = popcnt(bus.keep_insert);
        k_cnt = popcnt(bus.keep_in);
        sum   = r_q + k_cnt;
        din_m = bus.data_in & byte_mask(bus.keep_in);
        // Upper word is the output beat, lower word the bytes carried to the next beat.
        cat   = {res_q, {DATA_WD{1'b0}}}
              | ({{DATA_WD{1'b0}}, din_m} << (8 * (NBYTES - r_q)));

        if (load) valid_out_d = 1'b0;
        if (valid_out_q && bus.ready_out && last_out_q) begin
            pkt_cnt_d = pkt_cnt_q + {{(CNT_WD-1){1'b0}}, 1'b1};
        end

        unique case (state_q)
            IDLE: begin
                rdy_ins = 1'b1;
                if (bus.valid_insert) begin
                    res_d   = bus.header_insert << (8 * (NBYTES - h_cnt));
                    r_d     = h_cnt;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rdy_in = load;
                if (bus.valid_in && load) begin
                    valid_out_d = 1'b1;
                    data_out_d  = cat[2*DATA_WD-1 -: DATA_WD];
                    res_d       = cat[DATA_WD-1:0];
                    if (!bus.last_in) begin
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                    end else if (sum <= NBYTES) begin
                        keep_out_d = msb_ones(sum);
                        last_out_d = 1'b1;
                        res_d      = '0;
                        r_d        = '0;
                        state_d    = IDLE;
                    end else begin
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        r_d        = sum - NBYTES;
                        state_d    = TAIL;
                    end
                end
            end
            TAIL: begin
                if (load) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = msb_ones(r_q);
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    r_d         = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            r_q         <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            r_q         <= r_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign bus.ready_in     = rdy_in;
    assign bus.ready_insert = rdy_ins;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
    assign bus.pkt_cnt      = pkt_cnt_q;
endmodule
